// File: rtl/tjmono_rx_arbiter_pkg.sv
// rtl/tjmono_rx_arbiter_pkg.sv - shared tjmono readout constants
package tjmono_rx_arbiter_pkg;

    localparam int WORD_W = 32;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Width of a counter that must be able to hold max itself; 0 means unlimited.
    function automatic int cnt_w(input int max);
        return (max > 0) ? $clog2(max + 1) : 1;
    endfunction

endpackage

// File: rtl/tjmono_rr_pick.sv
// rtl/tjmono_rr_pick.sv - rotating priority search starting after ptr
module tjmono_rr_pick #(
    parameter int N_CH  = 4,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(N_CH);

    logic [IDX_W:0] sum;

    // Walk backwards so the candidate closest to ptr+1 is written last and wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int i = N_CH; i >= 1; i--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= N_L) begin
                sum = sum - N_L;
            end
            if (req[sum[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tjmono_rx_arbiter.sv
// rtl/tjmono_rx_arbiter.sv - round-robin merge of receiver FWFT FIFOs into one stream
module tjmono_rx_arbiter
    import tjmono_rx_arbiter_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST_N,
    input  logic [N_CH-1:0]          CH_EN,
    input  logic [N_CH-1:0]          CH_FIFO_EMPTY,
    input  logic [WORD_W*N_CH-1:0]   CH_FIFO_DATA,
    output logic [N_CH-1:0]          CH_FIFO_READ,
    input  logic                     OUT_FULL,
    output logic                     OUT_WRITE,
    output logic [WORD_W-1:0]        OUT_DATA,
    output logic [$clog2(N_CH)-1:0]  GRANT_CH,
    output logic [WORD_W-1:0]        WORD_CNT
);

    localparam int IDX_W = $clog2(N_CH);
    localparam int BC_W  = cnt_w(MAX_BURST);

    logic [0:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [BC_W-1:0]   burst_cnt;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic              g_en;
    logic              g_empty;
    logic              at_limit;
    logic              leave;
    logic              pop;
    logic [WORD_W-1:0] g_data;

    tjmono_rr_pick #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (CH_EN & ~CH_FIFO_EMPTY),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign g_en     = CH_EN[GRANT_CH];
    assign g_empty  = CH_FIFO_EMPTY[GRANT_CH];
    assign at_limit = (MAX_BURST != 0) && (burst_cnt == BC_W'(MAX_BURST));
    assign leave    = !g_en || g_empty || at_limit;
    // Reset gates the pop directly so no strobe leaks out before state settles.
    assign pop      = BUS_RST_N && (state == ST_GRANT) && !leave && !OUT_FULL;

    always_comb begin
        g_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (GRANT_CH == IDX_W'(k)) begin
                g_data = CH_FIFO_DATA[k*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        CH_FIFO_READ           = '0;
        CH_FIFO_READ[GRANT_CH] = pop;
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state     <= ST_IDLE;
            ptr       <= IDX_W'(N_CH - 1);
            GRANT_CH  <= '0;
            burst_cnt <= '0;
            OUT_WRITE <= 1'b0;
            OUT_DATA  <= '0;
            WORD_CNT  <= '0;
        end else begin
            OUT_WRITE <= pop;
            WORD_CNT  <= WORD_CNT + WORD_W'(pop);
            if (pop) begin
                OUT_DATA  <= g_data;
                burst_cnt <= burst_cnt + BC_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        GRANT_CH  <= pick_idx;
                        ptr       <= pick_idx;
                        burst_cnt <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (leave) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tjmono_rx_arbiter.sv
// tb/tb_tjmono_rx_arbiter.sv - directed scoreboard bench for tjmono_rx_arbiter
module tb_tjmono_rx_arbiter;

    logic         BUS_CLK = 1'b0;
    logic         BUS_RST_N;
    logic [3:0]   CH_EN;
    logic [3:0]   CH_FIFO_EMPTY;
    logic [127:0] CH_FIFO_DATA;
    logic [3:0]   CH_FIFO_READ;
    logic         OUT_FULL;
    logic         OUT_WRITE;
    logic [31:0]  OUT_DATA;
    logic [1:0]   GRANT_CH;
    logic [31:0]  WORD_CNT;

    always #5 BUS_CLK = ~BUS_CLK;

    tjmono_rx_arbiter #(
        .N_CH      (4),
        .MAX_BURST (16)
    ) dut (
        .BUS_CLK       (BUS_CLK),
        .BUS_RST_N     (BUS_RST_N),
        .CH_EN         (CH_EN),
        .CH_FIFO_EMPTY (CH_FIFO_EMPTY),
        .CH_FIFO_DATA  (CH_FIFO_DATA),
        .CH_FIFO_READ  (CH_FIFO_READ),
        .OUT_FULL      (OUT_FULL),
        .OUT_WRITE     (OUT_WRITE),
        .OUT_DATA      (OUT_DATA),
        .GRANT_CH      (GRANT_CH),
        .WORD_CNT      (WORD_CNT)
    );

    logic [31:0] fq [4][$];
    logic [31:0] sb [$];
    int          wr_log [$];
    bit          seen [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          writes = 0;
    int          pops = 0;
    int          pops_ch [4];
    bit          sb_on;
    logic [31:0] last_wr;
    int          first_wr_cyc;
    int          last_wr_cyc;

    function automatic logic [31:0] mk(input int t, input int ch, input int i);
        return 32'hA000_0000 | (32'(ch) << 24) | (32'(t) << 16) | 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int k = 0; k < 4; k++) begin
            CH_FIFO_EMPTY[k] = (fq[k].size() == 0);
            CH_FIFO_DATA[k*32 +: 32] = (fq[k].size() != 0) ? fq[k][0] : 32'h0;
        end
    endtask

    task automatic load(input int t, input int ch, input int n, input bit to_sb);
        for (int i = 1; i <= n; i++) begin
            fq[ch].push_back(mk(t, ch, i));
            if (to_sb) sb.push_back(mk(t, ch, i));
        end
        refresh();
    endtask

    // One clock: FIFO model pops on the strobe seen at the edge, output is checked at negedge.
    task automatic step();
        logic [3:0]  rd;
        logic [31:0] tmp;
        @(posedge BUS_CLK);
        rd = CH_FIFO_READ;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (rd[k]) begin
                chk("pop_nonempty", 32'(fq[k].size() > 0), 32'd1);
                if (fq[k].size() > 0) begin
                    tmp = fq[k].pop_front();
                    pops++;
                    pops_ch[k]++;
                end
            end
        end
        refresh();
        @(negedge BUS_CLK);
        cyc++;
        if (OUT_WRITE === 1'b1) begin
            writes++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            last_wr     = OUT_DATA;
            wr_log.push_back(cyc);
            chk("no_dup", 32'(seen.exists(OUT_DATA)), 32'd0);
            seen[OUT_DATA] = 1'b1;
            if (sb_on) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    tmp = sb.pop_front();
                    chk("sb_data", OUT_DATA, tmp);
                end
            end
        end
    endtask

    task automatic run_until_writes(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (writes < target && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(writes >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_read"},  32'(CH_FIFO_READ), 32'd0);
        chk({tag, "_write"}, 32'(OUT_WRITE),    32'd0);
        chk({tag, "_data"},  OUT_DATA,          32'd0);
        chk({tag, "_grant"}, 32'(GRANT_CH),     32'd0);
        chk({tag, "_cnt"},   WORD_CNT,          32'd0);
    endtask

    initial begin
        int w0;
        int p1;
        int wb;
        int n;
        bit stalled;

        for (int k = 0; k < 4; k++) pops_ch[k] = 0;
        BUS_RST_N    = 1'b0;
        CH_EN        = 4'hF;
        OUT_FULL     = 1'b0;
        sb_on        = 1'b1;
        first_wr_cyc = -1;
        last_wr_cyc  = 0;
        last_wr      = '0;
        refresh();
        #1;
        check_reset_outputs("reset");
        step();
        step();
        BUS_RST_N = 1'b1;
        step();
        chk("idle_no_write", 32'(OUT_WRITE), 32'd0);

        // Single channel: five words from ch0 in consecutive cycles.
        chk("t1_no_read_idle", 32'(CH_FIFO_READ), 32'd0);
        load(0, 0, 5, 1'b1);
        w0 = writes;
        first_wr_cyc = -1;
        step();
        chk("t1_read_first", 32'(CH_FIFO_READ), 32'h1);
        chk("t1_grant", 32'(GRANT_CH), 32'd0);
        run_until_writes("t1_timeout", w0 + 5, 20);
        chk("t1_consecutive", 32'(last_wr_cyc - first_wr_cyc), 32'd4);
        chk("t1_word_cnt", WORD_CNT, 32'd5);
        chk("t1_sb_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 3; i++) step();

        // Disable ch1 after three words; ch2 takes the next grant.
        load(2, 1, 10, 1'b0);
        load(2, 2, 4, 1'b0);
        for (int i = 1; i <= 3; i++) sb.push_back(mk(2, 1, i));
        for (int i = 1; i <= 4; i++) sb.push_back(mk(2, 2, i));
        w0 = writes;
        p1 = pops_ch[1];
        n  = 0;
        while (pops_ch[1] < p1 + 3 && n < 30) begin
            step();
            n++;
        end
        chk("t2_timeout_pop", 32'(pops_ch[1] - p1), 32'd3);
        CH_EN = 4'b1101;
        #1;
        chk("t2_read_drop", 32'(CH_FIFO_READ[1]), 32'd0);
        run_until_writes("t2_timeout", w0 + 7, 40);
        for (int i = 0; i < 3; i++) step();
        chk("t2_grant_ch2", 32'(GRANT_CH), 32'd2);
        chk("t2_ch1_left", 32'(fq[1].size()), 32'd7);
        chk("t2_ch1_pops", 32'(pops_ch[1] - p1), 32'd3);
        chk("t2_sb_drained", 32'(sb.size()), 32'd0);

        // Backpressure mid-burst on ch2; stall must not consume the burst budget.
        load(3, 2, 20, 1'b1);
        w0 = writes;
        wr_log.delete();
        stalled = 1'b0;
        n = 0;
        while (writes < w0 + 20 && n < 200) begin
            step();
            n++;
            if (!stalled && writes - w0 >= 5) begin
                stalled  = 1'b1;
                OUT_FULL = 1'b1;
                #1;
                chk("t3_read_full", 32'(CH_FIFO_READ), 32'd0);
                for (int i = 0; i < 10; i++) begin
                    step();
                    chk("t3_read_stall", 32'(CH_FIFO_READ), 32'd0);
                    chk("t3_write_stall", 32'(OUT_WRITE), 32'd0);
                end
                OUT_FULL = 1'b0;
            end
        end
        chk("t3_timeout", 32'(writes - w0), 32'd20);
        if (wr_log.size() >= 17) begin
            chk("t3_burst_inner", 32'(wr_log[15] - wr_log[14]), 32'd1);
            chk("t3_burst_end16", 32'(wr_log[16] - wr_log[15]), 32'd3);
        end
        chk("t3_sb_drained", 32'(sb.size()), 32'd0);
        fq[1].delete();
        CH_EN = 4'hF;
        refresh();
        for (int i = 0; i < 3; i++) step();

        // Fairness: 4 x 40 words, bursts 16,16,8 in order 0,1,2,3.
        BUS_RST_N = 1'b0;
        step();
        step();
        BUS_RST_N = 1'b1;
        for (int k = 0; k < 4; k++) load(4, k, 40, 1'b0);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 4; k++)
                for (int i = 1; i <= ((r < 2) ? 16 : 8); i++)
                    sb.push_back(mk(4, k, r * 16 + i));
        w0 = writes;
        first_wr_cyc = -1;
        run_until_writes("t4_timeout", w0 + 160, 400);
        chk("t4_span", 32'(last_wr_cyc - first_wr_cyc), 32'd181);
        chk("t4_word_cnt", WORD_CNT, 32'd160);
        chk("t4_sb_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 3; i++) step();

        // Reset during a ch2 burst; ch0 must win first afterwards.
        sb_on = 1'b0;
        load(5, 2, 10, 1'b0);
        w0 = writes;
        run_until_writes("t5_timeout_pre", w0 + 4, 20);
        load(5, 0, 3, 1'b0);
        BUS_RST_N = 1'b0;
        #1;
        check_reset_outputs("t5_reset");
        step();
        step();
        BUS_RST_N = 1'b1;
        wb = writes;
        run_until_writes("t5_timeout_post", wb + 1, 20);
        chk("t5_first_ch0", last_wr, mk(5, 0, 1));
        n = 0;
        while ((fq[0].size() != 0 || fq[2].size() != 0) && n < 60) begin
            step();
            n++;
        end
        for (int i = 0; i < 3; i++) step();
        chk("t5_drained", 32'(fq[0].size() + fq[2].size()), 32'd0);
        chk("t5_no_loss", 32'(writes), 32'(pops));
        sb_on = 1'b1;

        // WORD_CNT wrap.
        force dut.WORD_CNT = 32'hFFFF_FFFE;
        step();
        release dut.WORD_CNT;
        #1;
        chk("t6_preset", WORD_CNT, 32'hFFFF_FFFE);
        load(6, 3, 3, 1'b1);
        w0 = writes;
        run_until_writes("t6_timeout", w0 + 3, 20);
        chk("t6_wrap", WORD_CNT, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tjmono_rx_arbiter.md
TJMONO_RX_ARBITER -- requirements
Module: tjmono_rx_arbiter

Interface
REQ-001 Parameter N_CH, default 4, SHALL set the number of receiver channels (2..8).
REQ-002 Parameter MAX_BURST, default 16, SHALL set the maximum words per grant; 0 means unlimited.
REQ-003 BUS_CLK  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 BUS_RST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 CH_EN  input  N_CH  SHALL carry the per-channel enable mask.
REQ-006 CH_FIFO_EMPTY  input  N_CH  SHALL carry the per-channel FWFT FIFO empty flags.
REQ-007 CH_FIFO_DATA  input  32*N_CH  SHALL carry the per-channel FWFT head words; channel k occupies bits [32k+31:32k].
REQ-008 CH_FIFO_READ  output  N_CH  SHALL carry the per-channel pop strobes.
REQ-009 OUT_FULL  input  1  SHALL be the downstream almost-full flag, asserted with at least 1 free slot of margin.
REQ-010 OUT_WRITE  output  1  SHALL be the downstream write strobe.
REQ-011 OUT_DATA  output  32  SHALL carry the downstream data word.
REQ-012 GRANT_CH  output  clog2(N_CH)  SHALL carry the currently or last granted channel index.
REQ-013 WORD_CNT  output  32  SHALL carry the count of words forwarded since reset.

Function
REQ-014 The FSM SHALL have two states: IDLE and GRANT.
REQ-015 In IDLE, the block SHALL select the first channel k where CH_EN[k] is 1 and CH_FIFO_EMPTY[k] is 0, searching from the round-robin pointer plus 1 modulo N_CH.
- On a match: GRANT_CH and the pointer SHALL be set to k, burst_cnt SHALL be cleared, and the FSM SHALL go to GRANT.
- With no match: the FSM SHALL remain in IDLE.
REQ-016 In GRANT, CH_FIFO_READ[g] SHALL be a combinational 1 exactly when CH_EN[g] is 1, CH_FIFO_EMPTY[g] is 0, OUT_FULL is 0, and the burst limit is not reached. All other CH_FIFO_READ bits SHALL be 0 at all times.
REQ-017 For every pop, OUT_DATA SHALL be registered with the popped word and OUT_WRITE SHALL be 1 on the next cycle (latency 1). Otherwise OUT_WRITE SHALL be 0 and OUT_DATA SHALL hold its last value.
REQ-018 Each pop SHALL increment burst_cnt (width clog2(MAX_BURST+1)) and WORD_CNT. WORD_CNT SHALL wrap from 0xFFFFFFFF to 0.
REQ-019 In GRANT, the FSM SHALL return to IDLE on the cycle after any of these conditions, with no pop in the cycle the condition is observed:
- CH_EMPTY[g] is 1
- CH_EN[g] is 0
- burst_cnt equals MAX_BURST (only when MAX_BURST is not 0)
REQ-020 When OUT_FULL is 1 in GRANT, the block SHALL stall: no pop, burst_cnt held, state held. The stall SHALL NOT count toward the burst limit.
REQ-021 When the burst limit coincides with the channel going empty, the resulting single IDLE transition SHALL apply.
REQ-022 When only one channel is eligible, it SHALL be re-granted after exactly one IDLE cycle.
REQ-023 Changes to CH_EN in IDLE SHALL take effect in the same cycle's arbitration.
REQ-024 The block SHALL never pop a word without writing it downstream, and SHALL never write downstream without a pop.

Reset
REQ-025 Asserting BUS_RST_N low SHALL immediately force the following, mid-transfer included:
- state to IDLE
- CH_FIFO_READ to 0, OUT_WRITE to 0, OUT_DATA to 0
- GRANT_CH to 0, WORD_CNT to 0, burst_cnt to 0
- the pointer to N_CH-1, so that channel 0 wins first
REQ-026 A word popped in the cycle of reset assertion MAY be lost; no partial or duplicated word SHALL appear after reset.

Structure
REQ-027 The FSM state encoding and the 32-bit data-word width constant SHALL live in the shared tjmono readout package.
REQ-028 The rotating priority search SHALL be one sub-module, tjmono_rr_pick, taking (req, ptr) and returning (valid, idx) combinationally.
REQ-029 All other logic SHALL be flat in tjmono_rx_arbiter.

Verification
REQ-030 Single channel: ch0 preloaded with 5 words 0xA0000001..5, others empty, CH_EN=0xF → OUT_WRITE pulses 5 times in consecutive cycles with those values in order; WORD_CNT=5; CH_FIFO_READ[0] first high 1 cycle after GRANT entry.
REQ-031 Fairness: all 4 channels hold 40 words, MAX_BURST=16 → grant sequence is 0,1,2,3,0,1,2,3,0,1,2,3 with bursts 16,16,8; one IDLE cycle between bursts; 160 words total.
REQ-032 Backpressure: OUT_FULL high for 10 cycles mid-burst → no CH_FIFO_READ and no OUT_WRITE during those cycles; the burst resumes and still totals 16 words; no loss or duplication.
REQ-033 Disable mid-grant: CH_EN[1] dropped after 3 words of a burst → no further pops from ch1; the next grant goes to ch2; ch1's remaining words stay in its FIFO.
REQ-034 Reset mid-burst: BUS_RST_N low for 2 cycles during a ch2 burst → all outputs 0 immediately; after release, the first grant is ch0 (if non-empty); the scoreboard shows no duplicated words.
REQ-035 Wrap: WORD_CNT forced to 0xFFFFFFFE, then 3 words forwarded → reads 0x00000001.
